// File: rtl/wb_copy_master.sv
// wb_copy_master: Wishbone classic initiator copying a block of 32-bit words src -> dst
// Optional bus timeout abort is enabled by defining WB_TIMEOUT_EN.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (ready only while idle)
//   cmd_src, cmd_dst, cmd_len     source/destination byte address, word count
//   busy, done, err               status: in progress, completion pulse, timeout pulse
//   wbm_cyc_o .. wbm_dat_o        Wishbone initiator outputs (all registered)
//   wbm_dat_i, wbm_ack_i          Wishbone read data and acknowledge
module wb_copy_master #(
  parameter int LEN_W     = 8,
  parameter int ADDR_STEP = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_src,
  input  logic [31:0]      cmd_dst,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i
);
  typedef enum logic [2:0] {IDLE, RD, RGAP, WR, WGAP, FIN} state_t;
  state_t           state_q;
  logic [31:0]      src_q, dst_q, adr_q, data_q;
  logic [LEN_W-1:0] rem_q;
  logic             ready_q, busy_q, done_q, stb_q, we_q;
`ifdef WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt_q;
  logic          err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  // cyc and stb are never separated: each word is two single-beat classic cycles
  assign wbm_cyc_o = stb_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = {4{stb_q}};
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = data_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      adr_q   <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
`ifdef WB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef WB_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: if (cmd_valid) begin
          src_q   <= cmd_src;
          dst_q   <= cmd_dst;
          rem_q   <= cmd_len;
          busy_q  <= 1'b1;
          ready_q <= 1'b0;
          if (cmd_len == '0) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else begin
            state_q <= RD;
            stb_q   <= 1'b1;
            we_q    <= 1'b0;
            adr_q   <= cmd_src;
`ifdef WB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        RD, WR: if (wbm_ack_i) begin
          stb_q   <= 1'b0;
          we_q    <= 1'b0;
          state_q <= state_q == RD ? RGAP : WGAP;
          if (state_q == RD) data_q <= wbm_dat_i;
          else begin
            src_q <= src_q + 32'(ADDR_STEP);
            dst_q <= dst_q + 32'(ADDR_STEP);
            rem_q <= rem_q - LEN_W'(1);
          end
        end
`ifdef WB_TIMEOUT_EN
        // abort on the edge that completes TIMEOUT strobe cycles without ack
        else if (cnt_q == TW'(TIMEOUT - 1)) begin
          stb_q   <= 1'b0;
          we_q    <= 1'b0;
          err_q   <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end else cnt_q <= cnt_q + TW'(1);
`endif
        RGAP: begin
          state_q <= WR;
          stb_q   <= 1'b1;
          we_q    <= 1'b1;
          adr_q   <= dst_q;
`ifdef WB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        WGAP: if (rem_q == '0) begin
          state_q <= FIN;
          done_q  <= 1'b1;
        end else begin
          state_q <= RD;
          stb_q   <= 1'b1;
          adr_q   <= src_q;
`ifdef WB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_copy_master.sv
// tb_wb_copy_master: randomized self-checking bench with a Wishbone slave model
module tb_wb_copy_master;
  localparam logic [31:0] SEED = 32'h5A5A_1234;
  logic        clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0;
  logic [31:0] cmd_src = '0, cmd_dst = '0;
  logic [7:0]  cmd_len = '0;
  logic        cmd_ready, busy, done, err, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  int checks = 0, fails = 0, cyc_n = 0, viol = 0;
  int unsigned cur_delay = 0, wcnt = 0;
  bit rand_delay = 0, ack_en = 1;
  logic [64:0] log_q[$], exp_q[$];
  bit wait_prev = 0, ack_prev = 0, we_prev = 0;
  logic [31:0] adr_prev = '0, dat_prev = '0;

  wb_copy_master dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .busy(busy),
    .done(done), .err(err), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ SEED;
  endfunction

  // slave: source memory content is a fixed function of the address
  assign wbm_dat_i = mem_rd(wbm_adr_o);
  assign wbm_ack_i = ack_en && wbm_cyc_o && wbm_stb_o && (wcnt >= cur_delay);
  always @(posedge clk) begin
    if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) wcnt <= wcnt + 1;
    else begin
      wcnt      <= 0;
      cur_delay <= rand_delay ? $urandom_range(0, 7) : 0;
    end
  end

  // bus monitor: transaction log plus protocol rule violations
  always @(negedge clk) begin
    viol <= viol
      + int'(wait_prev && wbm_stb_o && (wbm_adr_o !== adr_prev || wbm_we_o !== we_prev ||
             (we_prev && wbm_dat_o !== dat_prev)))
      + int'(ack_prev && wbm_stb_o)
      + int'(wbm_sel_o !== (wbm_stb_o ? 4'hF : 4'h0))
      + int'(wbm_cyc_o !== wbm_stb_o)
      + int'(busy && cmd_ready);
    if (wbm_ack_i) log_q.push_back({wbm_we_o, wbm_adr_o, wbm_we_o ? wbm_dat_o : wbm_dat_i});
    wait_prev <= wbm_stb_o && !wbm_ack_i;
    ack_prev  <= wbm_ack_i;
    we_prev   <= wbm_we_o;
    adr_prev  <= wbm_adr_o;
    dat_prev  <= wbm_dat_o;
  end

  task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int l);
    exp_q.delete();
    for (int i = 0; i < l; i++) begin
      exp_q.push_back({1'b0, s + 32'(4 * i), mem_rd(s + 32'(4 * i))});
      exp_q.push_back({1'b1, d + 32'(4 * i), mem_rd(s + 32'(4 * i))});
    end
  endtask

  // returns at the negedge of the first cycle after acceptance
  task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [7:0] l);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!cmd_ready) begin fails++; $display("FAIL issue_ready: cmd_ready=%b required 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_src = s; cmd_dst = d; cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // k = cycle index after accept (1 = current) at which done was seen, 0 if never
  task automatic wait_done(input int maxc, input bit poke, output int k);
    k = 0;
    for (int i = 1; i <= maxc; i++) begin
      if (done) begin k = i; break; end
      if (poke) begin
        cmd_valid = 1'($urandom_range(0, 1)); cmd_src = $urandom; cmd_dst = $urandom;
        cmd_len = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, busy, done, err} !== 10'b0) begin
      fails++;
      $display("FAIL reset_ctrl: cyc/stb/we/sel/busy/done/err=%b required 0",
               {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, busy, done, err});
    end
    checks++;
    if ({wbm_adr_o, wbm_dat_o} !== 64'b0) begin
      fails++; $display("FAIL reset_bus: adr=%h dat=%h required 0", wbm_adr_o, wbm_dat_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b required 1", cmd_ready); end
  endtask

  task automatic test_basic_copy;
    int k;
    rand_delay = 0;
    log_q.delete();
    model_copy(32'h100, 32'h200, 3);
    issue(32'h100, 32'h200, 8'd3);
    wait_done(100, 0, k);
    checks++;
    if (k !== 13) begin fails++; $display("FAIL basic_done_cycle: got %0d required 13", k); end
    checks++;
    if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_at_done: got %b required 1", busy); end
    @(negedge clk);
    checks++;
    if ({busy, done, cmd_ready} !== 3'b001) begin
      fails++; $display("FAIL basic_after_done: busy/done/ready=%b required 001", {busy, done, cmd_ready});
    end
    checks++;
    if (log_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL basic_txn_count: got %0d required %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL basic_txn[%0d]: got %h required %h", i, i < log_q.size() ? log_q[i] : 65'bx, exp_q[i]);
      end
    end
    checks++;
    if (viol !== 0) begin fails++; $display("FAIL basic_protocol: %0d violations required 0", viol); end
  endtask

  task automatic test_len_zero;
    log_q.delete();
    issue(32'h400, 32'h500, 8'd0);
    checks++;
    if ({done, busy, wbm_stb_o, wbm_cyc_o} !== 4'b1100) begin
      fails++; $display("FAIL len0_fin: done/busy/stb/cyc=%b required 1100", {done, busy, wbm_stb_o, wbm_cyc_o});
    end
    @(negedge clk);
    checks++;
    if ({done, busy, cmd_ready} !== 3'b001) begin
      fails++; $display("FAIL len0_after: done/busy/ready=%b required 001", {done, busy, cmd_ready});
    end
    checks++;
    if (log_q.size() !== 0) begin fails++; $display("FAIL len0_bus: %0d transfers required 0", log_q.size()); end
  endtask

  task automatic test_random_copy;
    logic [31:0] s, d;
    int k, quiet = 0;
    rand_delay = 1;
    for (int r = 0; r < 2; r++) begin
      s = 32'h0001_0000 + 32'($urandom_range(0, 1023) << 2);
      d = s + 32'h0010_0000;
      log_q.delete();
      model_copy(s, d, 16);
      issue(s, d, 8'd16);
      wait_done(2000, 1, k);
      checks++;
      if (k == 0) begin fails++; $display("FAIL rand_done: no done within 2000 cycles required done"); end
      repeat (10) begin @(negedge clk); quiet += int'(wbm_stb_o); end
      checks++;
      if (log_q.size() !== 32 || quiet !== 0) begin
        fails++; $display("FAIL rand_no_extra_cmd: transfers=%0d idle_stb=%0d required 32 and 0", log_q.size(), quiet);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (i >= log_q.size() || log_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL rand_txn[%0d]: got %h required %h", i, i < log_q.size() ? log_q[i] : 65'bx, exp_q[i]);
        end
      end
    end
    checks++;
    if (viol !== 0) begin fails++; $display("FAIL rand_protocol: %0d violations required 0", viol); end
    rand_delay = 0;
  endtask

  task automatic test_wrap;
    int k;
    log_q.delete();
    model_copy(32'hFFFF_FFFC, 32'h0000_3000, 2);
    issue(32'hFFFF_FFFC, 32'h0000_3000, 8'd2);
    wait_done(100, 0, k);
    checks++;
    if (k !== 9) begin fails++; $display("FAIL wrap_done_cycle: got %0d required 9", k); end
    checks++;
    if (log_q.size() < 3 || log_q[2][63:32] !== 32'h0) begin
      fails++; $display("FAIL wrap_second_read: got %h required address 00000000", log_q.size() < 3 ? 65'bx : log_q[2]);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL wrap_txn[%0d]: got %h required %h", i, i < log_q.size() ? log_q[i] : 65'bx, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int n = 0, k;
    rand_delay = 1;
    issue(32'h800, 32'h900, 8'd4);
    while (!(wbm_stb_o && wbm_we_o) && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!(wbm_stb_o && wbm_we_o)) begin fails++; $display("FAIL rstmid_reach_wr: stb/we=%b%b required 11", wbm_stb_o, wbm_we_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, busy, done} !== 4'b0) begin
      fails++; $display("FAIL rstmid_drop: cyc/stb/busy/done=%b required 0000", {wbm_cyc_o, wbm_stb_o, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    rand_delay = 0;
    log_q.delete();
    model_copy(32'hA00, 32'hB00, 2);
    issue(32'hA00, 32'hB00, 8'd2);
    wait_done(100, 0, k);
    checks++;
    if (k !== 9) begin fails++; $display("FAIL rstmid_done_cycle: got %0d required 9", k); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL rstmid_txn[%0d]: got %h required %h", i, i < log_q.size() ? log_q[i] : 65'bx, exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout;
    int stb_n = 0, err_n = 0, done_n = 0;
    ack_en = 0;
    issue(32'hC00, 32'hD00, 8'd2);
    for (int i = 0; i < 300; i++) begin
      stb_n += int'(wbm_stb_o); err_n += int'(err); done_n += int'(done);
      @(negedge clk);
    end
`ifdef WB_TIMEOUT_EN
    checks++;
    if (stb_n !== 255) begin fails++; $display("FAIL timeout_stb_cycles: got %0d required 255", stb_n); end
    checks++;
    if (err_n !== 1 || done_n !== 0) begin
      fails++; $display("FAIL timeout_pulses: err=%0d done=%0d required 1 and 0", err_n, done_n);
    end
    checks++;
    if ({busy, cmd_ready} !== 2'b01) begin fails++; $display("FAIL timeout_idle: busy/ready=%b required 01", {busy, cmd_ready}); end
`else
    checks++;
    if (stb_n !== 300) begin fails++; $display("FAIL hold_stb_cycles: got %0d required 300", stb_n); end
    checks++;
    if (err_n !== 0 || done_n !== 0 || busy !== 1'b1) begin
      fails++; $display("FAIL hold_status: err=%0d done=%0d busy=%b required 0 0 1", err_n, done_n, busy);
    end
`endif
    ack_en = 1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_copy();
    test_len_zero();
    test_random_copy();
    test_wrap();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
